tmds_channel_decoder: RTL and testbench



---
 rtl/tmds_channel_decoder.sv | 167 ++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word alignment from control-token runs, then data/control decode.
// Optional statistics ports (lock_loss_count, slip_pulse) are built when TMDS_DEC_STATS_EN is defined.
//
// state     | meaning
// ST_SEARCH | hunting for LOCK_COUNT consecutive tokens; slips offset after SEARCH_TIMEOUT idle cycles
// ST_LOCKED | alignment fixed; drops back to search after SEARCH_TIMEOUT cycles without a token
module tmds_channel_decoder #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 1023
) (
  input  logic        clk_pixel,
  input  logic        rst_n,
  input  logic [9:0]  tmds_in,
  output logic [7:0]  data,
  output logic [1:0]  ctrl,
  output logic        de,
  output logic        locked,
  output logic [3:0]  bit_offset
`ifdef TMDS_DEC_STATS_EN
  ,
  output logic [15:0] lock_loss_count,
  output logic        slip_pulse
`endif
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int IDLE_W = $clog2(SEARCH_TIMEOUT + 1);

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  state_t            state, state_nxt;
  logic [RUN_W-1:0]  run_cnt, run_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic [3:0]        offset_nxt;
  logic [9:0]        r0, r1;
  logic [9:0]        word;
  logic              is_token;
  logic [1:0]        tok_val;
  logic [7:0]        q, dec;
  logic [7:0]        data_nxt;
  logic [1:0]        ctrl_nxt;
  logic              de_nxt;

  // r0 holds the older word, so {r1,r0} is the last 20 received bits in arrival order
  assign word   = 10'({r1, r0} >> bit_offset);
  assign locked = (state == ST_LOCKED);

  always_comb begin
    is_token = 1'b1;
    tok_val  = 2'b00;
    case (word)
      10'b1101010100: tok_val = 2'b00;
      10'b0010101011: tok_val = 2'b01;
      10'b0101010100: tok_val = 2'b10;
      10'b1010101011: tok_val = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  always_comb begin
    q      = word[9] ? ~word[7:0] : word[7:0];
    dec    = 8'd0;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++)
      dec[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SEARCH;
      run_cnt    <= '0;
      idle_cnt   <= '0;
      bit_offset <= 4'd0;
      r0         <= 10'd0;
      r1         <= 10'd0;
    end else begin
      state      <= state_nxt;
      run_cnt    <= run_nxt;
      idle_cnt   <= idle_nxt;
      bit_offset <= offset_nxt;
      r1         <= tmds_in;
      r0         <= r1;
    end
  end

  // A token on the timeout cycle clears idle first, so it always beats a slip or unlock
  always_comb begin
    state_nxt  = state;
    run_nxt    = run_cnt;
    idle_nxt   = idle_cnt;
    offset_nxt = bit_offset;
    case (state)
      ST_SEARCH: begin
        if (is_token) begin
          idle_nxt = '0;
          if (run_cnt == RUN_W'(LOCK_COUNT - 1)) begin
            state_nxt = ST_LOCKED;
            run_nxt   = '0;
          end else begin
            run_nxt = run_cnt + RUN_W'(1);
          end
        end else begin
          run_nxt = '0;
          if (idle_cnt == IDLE_W'(SEARCH_TIMEOUT - 1)) begin
            idle_nxt   = '0;
            offset_nxt = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
          end else begin
            idle_nxt = idle_cnt + IDLE_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        run_nxt = '0;
        if (is_token) begin
          idle_nxt = '0;
        end else if (idle_cnt == IDLE_W'(SEARCH_TIMEOUT - 1)) begin
          state_nxt = ST_SEARCH;
          idle_nxt  = '0;
        end else begin
          idle_nxt = idle_cnt + IDLE_W'(1);
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  always_comb begin
    data_nxt = 8'd0;
    ctrl_nxt = 2'b00;
    de_nxt   = 1'b0;
    if (state_nxt == ST_LOCKED) begin
      if (is_token) begin
        ctrl_nxt = tok_val;
      end else begin
        ctrl_nxt = ctrl;
        de_nxt   = 1'b1;
        data_nxt = dec;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      data <= 8'd0;
      ctrl <= 2'b00;
      de   <= 1'b0;
    end else begin
      data <= data_nxt;
      ctrl <= ctrl_nxt;
      de   <= de_nxt;
    end
  end

`ifdef TMDS_DEC_STATS_EN
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_count <= 16'd0;
      slip_pulse      <= 1'b0;
    end else begin
      slip_pulse <= (state == ST_SEARCH) && (offset_nxt != bit_offset);
      if (state == ST_LOCKED && state_nxt == ST_SEARCH && lock_loss_count != 16'hFFFF)
        lock_loss_count <= lock_loss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: expected outputs queued at drive time, compared three negedges later.
// Statistics ports are checked when TMDS_DEC_STATS_EN is defined.
module tb_tmds_channel_decoder;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic        clk_pixel = 1'b0;
  logic        rst_n     = 1'b0;
  logic [9:0]  tmds_in   = 10'd0;
  logic [7:0]  data;
  logic [1:0]  ctrl;
  logic        de;
  logic        locked;
  logic [3:0]  bit_offset;
`ifdef TMDS_DEC_STATS_EN
  logic [15:0] lock_loss_count;
  logic        slip_pulse;
  int          slip_cnt = 0;
`endif

  tmds_channel_decoder dut (
    .clk_pixel  (clk_pixel),
    .rst_n      (rst_n),
    .tmds_in    (tmds_in),
    .data       (data),
    .ctrl       (ctrl),
    .de         (de),
    .locked     (locked),
    .bit_offset (bit_offset)
`ifdef TMDS_DEC_STATS_EN
    ,
    .lock_loss_count (lock_loss_count),
    .slip_pulse      (slip_pulse)
`endif
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    int          due;
    logic        chk;
    logic [15:0] ev;
  } exp_t;

  exp_t  exp_q[$];
  int    cyc = 0;
  int    total = 0;
  int    passed = 0;
  string cur_test = "none";

  always @(posedge clk_pixel) cyc <= cyc + 1;

`ifdef TMDS_DEC_STATS_EN
  always @(negedge clk_pixel) if (slip_pulse) slip_cnt++;
`endif

  // scoreboard checker: outputs packed as {data,ctrl,de,locked,bit_offset}
  always @(negedge clk_pixel) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        total++;
        if ({data, ctrl, de, locked, bit_offset} !== e.ev)
          $display("FAIL %s cyc=%0d got=%h exp=%h", cur_test, cyc,
                   {data, ctrl, de, locked, bit_offset}, e.ev);
        else
          passed++;
      end
    end
  end

  function automatic logic [15:0] ev(input logic [7:0] d, input logic [1:0] c,
                                     input logic e, input logic l, input logic [3:0] o);
    return {d, c, e, l, o};
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] w);
    logic [7:0] q, d;
    q    = w[9] ? ~w[7:0] : w[7:0];
    d    = 8'd0;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic logic is_tok(input logic [9:0] w);
    return (w == T00) || (w == T01) || (w == T10) || (w == T11);
  endfunction

  task automatic drive(input logic [9:0] w, input logic chk, input logic [15:0] e);
    exp_t x;
    @(negedge clk_pixel);
    tmds_in = w;
    x.due = cyc + 3;
    x.chk = chk;
    x.ev  = e;
    exp_q.push_back(x);
  endtask

  task automatic drain();
    repeat (4) @(negedge clk_pixel);
  endtask

  task automatic do_reset();
    @(negedge clk_pixel);
    #2 rst_n = 1'b0;
    tmds_in = 10'd0;
    exp_q.delete();
    repeat (2) @(negedge clk_pixel);
    rst_n = 1'b1;
  endtask

  // 8 tokens from a fresh reset; lock declared on the 8th decision edge
  task automatic lock_with(input logic [9:0] t, input logic [1:0] c);
    for (int i = 1; i <= 8; i++)
      drive(t, 1'b1, (i == 8) ? ev(8'd0, c, 1'b0, 1'b1, 4'd0) : ev(8'd0, 2'b00, 1'b0, 1'b0, 4'd0));
  endtask

  task automatic test_reset();
    cur_test = "reset";
    do_reset();
    @(negedge clk_pixel);
    total++;
    if ({data, ctrl, de, locked, bit_offset} !== 16'd0)
      $display("FAIL reset_values got=%h exp=0000", {data, ctrl, de, locked, bit_offset});
    else passed++;
    for (int i = 0; i < 8; i++) drive(T11, 1'b0, 16'd0);
    drain();
    total++;
    if ({locked, ctrl} !== 3'b111) $display("FAIL pre_reset_lock got=%b exp=111", {locked, ctrl});
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({data, ctrl, de, locked, bit_offset} !== 16'd0)
      $display("FAIL async_reset got=%h exp=0000", {data, ctrl, de, locked, bit_offset});
    else passed++;
    exp_q.delete();
    @(negedge clk_pixel);
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    cur_test = "lock";
    do_reset();
    for (int i = 0; i < 7; i++) drive(T00, 1'b1, 16'd0);
    drive(10'h100, 1'b1, 16'd0);
    lock_with(T00, 2'b00);
    drive(T00, 1'b1, ev(8'd0, 2'b00, 1'b0, 1'b1, 4'd0));
    drain();
  endtask

  task automatic test_data();
    logic [9:0] w;
    cur_test = "data";
    do_reset();
    lock_with(T00, 2'b00);
    drive(T01,    1'b1, ev(8'h00, 2'b01, 1'b0, 1'b1, 4'd0));
    drive(10'h100, 1'b1, ev(8'h00, 2'b01, 1'b1, 1'b1, 4'd0));
    drive(10'h2FF, 1'b1, ev(8'hFE, 2'b01, 1'b1, 1'b1, 4'd0));
    drive(T10,    1'b1, ev(8'h00, 2'b10, 1'b0, 1'b1, 4'd0));
    for (int i = 0; i < 24; i++) begin
      do w = 10'($urandom_range(0, 1023)); while (is_tok(w));
      drive(w, 1'b1, ev(decode(w), 2'b10, 1'b1, 1'b1, 4'd0));
    end
    drive(T11, 1'b1, ev(8'h00, 2'b11, 1'b0, 1'b1, 4'd0));
    drive(10'h0F0, 1'b1, ev(decode(10'h0F0), 2'b11, 1'b1, 1'b1, 4'd0));
    drain();
  endtask

  task automatic test_timeout_unlock();
    cur_test = "timeout";
    do_reset();
    lock_with(T00, 2'b00);
    for (int i = 1; i <= 1022; i++) drive(10'h100, 1'b1, ev(8'h00, 2'b00, 1'b1, 1'b1, 4'd0));
    drive(10'h100, 1'b1, 16'd0);
    drive(10'h2FF, 1'b1, 16'd0);
    drain();
`ifdef TMDS_DEC_STATS_EN
    total++;
    if (lock_loss_count !== 16'd1) $display("FAIL lock_loss_count got=%0d exp=1", lock_loss_count);
    else passed++;
`endif
  endtask

  task automatic test_token_saves();
    cur_test = "token_race";
    do_reset();
    lock_with(T11, 2'b11);
    for (int i = 0; i < 1022; i++) drive(10'h100, 1'b1, ev(8'h00, 2'b11, 1'b1, 1'b1, 4'd0));
    drive(T01, 1'b1, ev(8'h00, 2'b01, 1'b0, 1'b1, 4'd0));
    for (int i = 0; i < 1022; i++) drive(10'h2FF, 1'b1, ev(8'hFE, 2'b01, 1'b1, 1'b1, 4'd0));
    drive(10'h2FF, 1'b1, 16'd0);
    drain();
  endtask

  task automatic test_slip();
    logic [9:0] carry;
    logic [3:0] prev;
    logic [3:0] offs[$];
    int         times[$];
    logic       seen_lock;
    logic       moved;
    cur_test = "slip";
    do_reset();
`ifdef TMDS_DEC_STATS_EN
    slip_cnt = 0;
`endif
    carry = 10'd0;
    prev = 4'd0;
    seen_lock = 1'b0;
    for (int c = 0; c < 6000 && !seen_lock; c++) begin
      @(negedge clk_pixel);
      if (bit_offset !== prev) begin
        offs.push_back(bit_offset);
        times.push_back(cyc);
        prev = bit_offset;
      end
      if (locked === 1'b1) seen_lock = 1'b1;
      tmds_in = {T00[6:0], carry[2:0]};
      carry   = {7'd0, T00[9:7]};
    end
    total++;
    if (!seen_lock) $display("FAIL slip_lock_timeout locked=%b exp=1", locked);
    else passed++;
    total++;
    if (offs.size() != 3) $display("FAIL slip_count got=%0d exp=3", offs.size());
    else if ({offs[0], offs[1], offs[2]} !== 12'h123)
      $display("FAIL slip_sequence got=%h exp=123", {offs[0], offs[1], offs[2]});
    else passed++;
    total++;
    if (times.size() < 3) $display("FAIL slip_spacing got=%0d slips exp=3", times.size());
    else if (times[1] - times[0] != 1023 || times[2] - times[1] != 1023)
      $display("FAIL slip_spacing got=%0d,%0d exp=1023", times[1] - times[0], times[2] - times[1]);
    else passed++;
    moved = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk_pixel);
      if (bit_offset !== 4'd3 || locked !== 1'b1) moved = 1'b1;
      tmds_in = {T00[6:0], carry[2:0]};
    end
    total++;
    if (moved) $display("FAIL hold_offset got=%0d/%b exp=3/1", bit_offset, locked);
    else passed++;
`ifdef TMDS_DEC_STATS_EN
    total++;
    if (slip_cnt != 3) $display("FAIL slip_pulses got=%0d exp=3", slip_cnt);
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_lock();
    test_data();
    test_timeout_unlock();
    test_token_saves();
    test_slip();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
